// File: rtl/hsst_sync_fifo_pkg.sv
// Shared constants and helpers for the HSST single-clock FIFO family.
package hsst_fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Bits needed to hold a fill level of 0..cap inclusive.
    function automatic int unsigned level_width(input int unsigned cap);
        return int'($clog2(cap)) + 1;
    endfunction

endpackage

// File: rtl/hsst_sync_fifo_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module hsst_sync_fifo_sdpram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; output register holds when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hsst_sync_fifo.sv
// Parametrised single-clock FIFO with standard/FWFT read, programmable
// almost thresholds, exact water level and sticky error flags.
module hsst_sync_fifo
    import hsst_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH_WIDTH = 8,
    parameter int unsigned FWFT        = 0,
    parameter int unsigned AF_RESET    = 252,
    parameter int unsigned AE_RESET    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    input  logic                   thr_we,
    input  logic [DEPTH_WIDTH:0]   af_thresh_in,
    input  logic [DEPTH_WIDTH:0]   ae_thresh_in,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int unsigned CAP     = 2 ** DEPTH_WIDTH;
    localparam int unsigned LW      = level_width(CAP);
    localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]          af_thresh;
    logic [LW-1:0]          ae_thresh;
    logic [LW-1:0]          level_next;
    logic                   out_valid;      // FWFT: RAM output register holds the head word
    logic                   ram_vld;        // standard: RAM output captured at the last edge
    logic [DATA_WIDTH-1:0]  ram_dout;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   wr_acc_c;
    logic                   rd_acc_c;
    logic                   ram_re_c;
    logic                   out_valid_next;

    // Accept decisions, next level and RAM read scheduling (prefetch in FWFT).
    always_comb begin
        wr_acc_c       = wr_en && !wr_full;
        rd_acc_c       = rd_en && !rd_empty;
        level_next     = water_level;
        ram_re_c       = rd_acc_c;
        out_valid_next = 1'b0;
        if (wr_acc_c && !rd_acc_c) begin
            level_next = water_level + LW'(1);
        end else if (!wr_acc_c && rd_acc_c) begin
            level_next = water_level - LW'(1);
        end
        if (IS_FWFT) begin
            // Words still in RAM = level minus the prefetched head.
            ram_re_c       = (water_level != LW'(out_valid)) && (!out_valid || rd_acc_c);
            out_valid_next = ram_re_c || (out_valid && !rd_acc_c);
        end
    end

    // Pointers, level, registered flags, thresholds and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= (LW'(AF_RESET) == '0);
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            out_valid    <= 1'b0;
            ram_vld      <= 1'b0;
            rd_valid     <= 1'b0;
            data_q       <= '0;
            af_thresh    <= LW'(AF_RESET);
            ae_thresh    <= LW'(AE_RESET);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            end
            if (ram_re_c) begin
                rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            end
            water_level  <= level_next;
            wr_full      <= (level_next == LW'(CAP));
            almost_full  <= (level_next >= af_thresh);
            almost_empty <= (level_next <= ae_thresh);
            rd_empty     <= IS_FWFT ? !out_valid_next : (level_next == '0);
            out_valid    <= out_valid_next;
            ram_vld      <= !IS_FWFT && rd_acc_c;
            rd_valid     <= IS_FWFT ? out_valid_next : ram_vld;
            if (ram_vld) begin
                data_q <= ram_dout;
            end
            if (thr_we) begin
                af_thresh <= af_thresh_in;
                ae_thresh <= ae_thresh_in;
            end
            // A new error in the same cycle as clr_err keeps the flag set.
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // FWFT presents the RAM output register directly; standard adds one stage.
    assign rd_data = IS_FWFT ? ram_dout : data_q;

    hsst_sync_fifo_sdpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_c && !rst),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (ram_re_c && !rst),
        .raddr (rd_ptr),
        .rdata (ram_dout)
    );

endmodule
